// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: stage codes driven to the stage decoder and
// the sequencer state type.
package cpu_ctrl_pkg;

  localparam logic [1:0] STG_FETCH  = 2'b00;
  localparam logic [1:0] STG_DECODE = 2'b01;
  localparam logic [1:0] STG_EXEC   = 2'b10;
  localparam logic [1:0] STG_WB     = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalted
  } cpu_state_e;

  // Stage code presented for a given state; IDLE/HALTED show FETCH's code
  // but are qualified off by stage_valid.
  function automatic logic [1:0] stage_of(cpu_state_e s);
    logic [1:0] code;
    code = STG_FETCH;
    case (s)
      StDecode: code = STG_DECODE;
      StExec:   code = STG_EXEC;
      StWb:     code = STG_WB;
      default:  code = STG_FETCH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts non-stalled FETCH wait cycles; flags the cycle in which one more
// wait would reach the timeout limit.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High while the current wait cycle is the TIMEOUT-th one.
  assign expired = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle CPU stage sequencer: walks FETCH/DECODE/EXEC/WB, handles fetch
// handshake, stall, flush, halt, fetch timeout and retired-instruction count.
module cpu_stage_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_ready,
  input  logic             halt_instr,
  input  logic             ex_multi,
  input  logic             ex_done,
  output logic [1:0]       stage,
  output logic             stage_valid,
  output logic             mem_req,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             halted,
  output logic             fault
);

  cpu_state_e       state_q, state_d;
  logic             retire_d, fault_d;
  logic [CNT_W-1:0] retire_count_d;
  logic             to_clr, to_en, to_expired;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_fetch_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  // Next-state logic; priority flush > stall > normal, except mem_ready beats stall in FETCH.
  always_comb begin
    state_d        = state_q;
    retire_d       = 1'b0;
    fault_d        = fault;
    retire_count_d = retire_count;
    to_clr         = 1'b1;
    to_en          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        to_clr = 1'b0;
        if (flush) begin
          to_clr = 1'b1;
        end else if (mem_ready) begin
          to_clr  = 1'b1;
          state_d = StDecode;
        end else if (!stall) begin
          if (to_expired) begin
            to_clr  = 1'b1;
            state_d = StHalted;
            fault_d = 1'b1;
          end else begin
            to_en = 1'b1;
          end
        end
      end
      StDecode: begin
        if (flush) begin
          state_d = StFetch;
        end else if (!stall) begin
          state_d = halt_instr ? StHalted : StExec;
        end
      end
      StExec: begin
        if (flush) begin
          state_d = StFetch;
        end else if (!stall && (!ex_multi || ex_done)) begin
          state_d = StWb;
        end
      end
      StWb: begin
        // flush is deliberately ignored here: the instruction already completed.
        if (!stall) begin
          state_d        = StFetch;
          retire_d       = 1'b1;
          retire_count_d = retire_count + 1'b1;
        end
      end
      StHalted: begin
        if (start) begin
          state_d = StFetch;
          fault_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      stage        <= STG_FETCH;
      stage_valid  <= 1'b0;
      mem_req      <= 1'b0;
      retire       <= 1'b0;
      retire_count <= '0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage        <= stage_of(state_d);
      stage_valid  <= state_d inside {StFetch, StDecode, StExec, StWb};
      mem_req      <= (state_d == StFetch);
      retire       <= retire_d;
      retire_count <= retire_count_d;
      halted       <= (state_d == StHalted);
      fault        <= fault_d;
    end
  end

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench for cpu_stage_sequencer: the stimulus process predicts the
// outputs after each clock edge from a behavioural model and queues them; the
// monitor process compares the DUT against the queue after every edge.
module tb_cpu_stage_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic             clk, reset, start, stall, flush, mem_ready, halt_instr, ex_multi, ex_done;
  logic [1:0]       stage;
  logic             stage_valid, mem_req, retire, halted, fault;
  logic [CNT_W-1:0] retire_count;

  cpu_stage_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .flush        (flush),
    .mem_ready    (mem_ready),
    .halt_instr   (halt_instr),
    .ex_multi     (ex_multi),
    .ex_done      (ex_done),
    .stage        (stage),
    .stage_valid  (stage_valid),
    .mem_req      (mem_req),
    .retire       (retire),
    .retire_count (retire_count),
    .halted       (halted),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       stage;
    logic             valid;
    logic             mreq;
    logic             ret;
    logic [CNT_W-1:0] cnt;
    logic             halted;
    logic             fault;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural model: running flag, stage number 0..3 (fetch..writeback),
  // number of fetch wait cycles so far, retired count as a plain integer.
  bit m_run, m_halted, m_fault, m_retire;
  int m_stage, m_wait, m_count;

  function automatic logic [1:0] stage_code(int s);
    case (s)
      0:       return STG_FETCH;
      1:       return STG_DECODE;
      2:       return STG_EXEC;
      default: return STG_WB;
    endcase
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.stage  = m_run ? stage_code(m_stage) : STG_FETCH;
    o.valid  = m_run;
    o.mreq   = m_run && (m_stage == 0);
    o.ret    = m_retire;
    o.cnt    = CNT_W'(m_count);
    o.halted = m_halted;
    o.fault  = m_fault;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {stage, stage_valid, mem_req, retire, retire_count, halted, fault};
    return o;
  endfunction

  task automatic model_reset();
    m_run = 0; m_halted = 0; m_fault = 0; m_retire = 0;
    m_stage = 0; m_wait = 0; m_count = 0;
  endtask

  // One clock edge of the instruction-level rules, using the current inputs.
  task automatic model_step();
    m_retire = 0;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_halted = 0; m_fault = 0; m_stage = 0; m_wait = 0;
      end
    end else begin
      case (m_stage)
        0: begin
          if (flush) m_wait = 0;
          else if (mem_ready) begin m_stage = 1; m_wait = 0; end
          else if (!stall) begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
              m_run = 0; m_halted = 1; m_fault = 1; m_wait = 0;
            end
          end
        end
        1: begin
          if (flush) m_stage = 0;
          else if (!stall) begin
            if (halt_instr) begin m_run = 0; m_halted = 1; end
            else m_stage = 2;
          end
        end
        2: begin
          if (flush) m_stage = 0;
          else if (!stall && (!ex_multi || ex_done)) m_stage = 3;
        end
        default: begin
          if (!stall) begin
            m_stage = 0; m_retire = 1; m_count = (m_count + 1) % (1 << CNT_W);
          end
        end
      endcase
    end
  endtask

  task automatic report(input string name, input obs_t a, input obs_t e);
    $display("FAIL %s @%0t: got stage=%0d valid=%0b mreq=%0b retire=%0b count=%0d halted=%0b fault=%0b, want stage=%0d valid=%0b mreq=%0b retire=%0b count=%0d halted=%0b fault=%0b",
             name, $time, a.stage, a.valid, a.mreq, a.ret, a.cnt, a.halted, a.fault,
             e.stage, e.valid, e.mreq, e.ret, e.cnt, e.halted, e.fault);
  endtask

  // Drive one cycle of inputs and queue the predicted post-edge outputs.
  task automatic cycle(input logic st, input logic fl, input logic sl, input logic mr,
                       input logic hi, input logic em, input logic ed);
    @(negedge clk);
    reset = 0; start = st; flush = fl; stall = sl; mem_ready = mr;
    halt_instr = hi; ex_multi = em; ex_done = ed;
    model_step();
    exp_q.push_back(model_out());
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    obs_t a;
    obs_t e;
    @(negedge clk);
    #2 reset = 1;
    #1;
    model_reset();
    e = model_out();
    a = sample();
    n_vec++;
    if (a !== e) begin
      n_err++;
      report("async_reset", a, e);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare after every active edge against the next queued prediction.
  initial begin
    obs_t a;
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = sample();
        n_vec++;
        if (a !== e) begin
          n_err++;
          report("edge_outputs", a, e);
        end
      end
    end
  end

  initial begin
    reset = 1; start = 0; stall = 0; flush = 0; mem_ready = 0;
    halt_instr = 0; ex_multi = 0; ex_done = 0;
    model_reset();
    async_reset();
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);

    // Back-to-back 4-cycle instruction with mem_ready tied high.
    cycle(1, 0, 0, 1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 1, 0, 0, 0);

    // Slow fetch (3 waits) and a 3-cycle multi-cycle execute.
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Fetch timeout, ignored stall/flush while halted, then restart.
    repeat (15) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // Flush with stall in EXEC, then a 3-cycle stall in WB.
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);

    // HALT instruction, restart, then reset in the middle of FETCH.
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    async_reset();

    // Sixteen instructions wrap the 4-bit retire counter to zero.
    cycle(1, 0, 0, 1, 0, 0, 0);
    repeat (64) cycle(0, 0, 0, 1, 0, 0, 0);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0);
      end
    end

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
